// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: byte/half/word loads and stores over a
// variable-latency ack bus. Optional WAIT timeout is enabled by defining MEM_ACC_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_aluResult,
    input  logic [31:0] MEM_rtData,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_MemSize,
    input  logic        MEM_MemSigned,
    output logic [31:0] dmOut,
    output logic        stall,
    output logic        addr_exc,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    if ((64'd1 << TO_W) <= 64'(TIMEOUT)) begin : g_bad_cfg
        $error("TO_W too narrow for TIMEOUT");
    end

    state_t      state_q, state_d;
    logic [31:0] dmout_q, dmout_d;
    logic        addr_exc_q, addr_exc_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    // Load formatting attributes, captured with the request.
    logic [1:0]  lo_q, lo_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;

    logic        access, misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

`ifdef MEM_ACC_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
`endif

    // Request decode, lane steering and load formatting.
    always_comb begin
        access     = MEM_MemRead | MEM_MemWrite;
        misaligned = ((MEM_MemSize == 2'b01) & MEM_aluResult[0]) |
                     (MEM_MemSize[1] & (|MEM_aluResult[1:0]));

        be_new    = 4'b1111;
        wdata_new = MEM_rtData;
        case (MEM_MemSize)
            2'b00: begin
                be_new    = 4'b0001 << MEM_aluResult[1:0];
                wdata_new = {4{MEM_rtData[7:0]}};
            end
            2'b01: begin
                be_new    = MEM_aluResult[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{MEM_rtData[15:0]}};
            end
            default: ;
        endcase

        case (lo_q)
            2'b00:   byte_sel = bus_rdata[7:0];
            2'b01:   byte_sel = bus_rdata[15:8];
            2'b10:   byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (size_q)
            2'b00:   load_fmt = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_fmt = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_fmt = bus_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every signal is given its hold value first so no path can infer a latch.
        state_d     = state_q;
        dmout_d     = dmout_q;
        addr_exc_d  = addr_exc_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        lo_d        = lo_q;
        size_d      = size_q;
        signed_d    = signed_q;
`ifdef MEM_ACC_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
`endif
        stall = (state_q == S_WAIT) | ((state_q == S_IDLE) & access);

        case (state_q)
            S_IDLE: begin
                if (access && misaligned) begin
                    state_d    = S_DONE;
                    addr_exc_d = 1'b1;
                    dmout_d    = 32'h0;
                end else if (access) begin
                    state_d     = S_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = MEM_MemWrite;
                    bus_addr_d  = {MEM_aluResult[31:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
                    lo_d        = MEM_aluResult[1:0];
                    size_d      = MEM_MemSize;
                    signed_d    = MEM_MemSigned;
`ifdef MEM_ACC_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            S_WAIT: begin
                if (bus_ack) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) dmout_d = load_fmt;
                end
`ifdef MEM_ACC_TIMEOUT_EN
                // A late ack on the timeout cycle still completes normally.
                else if (cnt_q == TO_W'(TIMEOUT)) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    dmout_d   = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d    = S_IDLE;
                addr_exc_d = 1'b0;
`ifdef MEM_ACC_TIMEOUT_EN
                bus_err_d  = 1'b0;
`endif
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dmout_q     <= 32'h0;
            addr_exc_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            lo_q        <= 2'b00;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dmout_q     <= dmout_d;
            addr_exc_q  <= addr_exc_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
        end
    end

`ifdef MEM_ACC_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign dmOut     = dmout_q;
    assign addr_exc  = addr_exc_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
